// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches 1-3 byte instructions from byte memory and offers them to execute with valid/ready.
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [23:0] opcode,
  output logic [1:0]  op_len,
  output logic        op_illegal,
  output logic        op_valid,
  input  logic        op_ready,
  input  logic        jump_en,
  input  logic [7:0]  jump_addr,
  input  logic        halt,
  output logic        halted
);
  typedef enum logic [1:0] {FETCH0, FETCHN, ISSUE, HALTED} state_t;
  state_t state, state_nx;
  logic [7:0] pc, b0, b1, b2;
  logic got1, take, accept;
  assign mem_req    = state == FETCH0 || state == FETCHN;
  assign mem_addr   = pc;
  assign op_valid   = state == ISSUE;
  assign halted     = state == HALTED;
  assign opcode     = {b0, b1, b2};
  assign op_illegal = &b0[7:6];
  assign op_len     = b0[7:6] == 2'b10 ? 2'd3 : b0[7:6] == 2'b01 ? 2'd2 : 2'd1;
  assign take       = mem_req && mem_ack;
  assign accept     = op_valid && op_ready;
  // Length codes 00 and 11 are both single-byte instructions.
  always_comb begin
    state_nx = state;
    case (state)
      FETCH0:  state_nx = !take ? FETCH0 : mem_rdata[7] == mem_rdata[6] ? ISSUE : FETCHN;
      FETCHN:  state_nx = take && (got1 || op_len == 2'd2) ? ISSUE : FETCHN;
      ISSUE:   state_nx = !accept ? ISSUE : halt ? HALTED : FETCH0;
      default: state_nx = HALTED;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH0;
      pc    <= RESET_PC;
      b0    <= 8'h00;
      b1    <= 8'h00;
      b2    <= 8'h00;
      got1  <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) pc <= pc + 8'd1;
      else if (accept && jump_en) pc <= jump_addr;
      if (take && state == FETCH0) begin
        b0   <= mem_rdata;
        b1   <= 8'h00;
        b2   <= 8'h00;
        got1 <= 1'b0;
      end
      if (take && state == FETCHN) begin
        if (got1) b2 <= mem_rdata;
        else b1 <= mem_rdata;
        got1 <= 1'b1;
      end
    end
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00, meaning the fetch address loaded on reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port mem_req, output, 1, byte-read request to program memory.
REQ-005 The block SHALL have port mem_addr, output, 8, byte address of the current request (equals pc).
REQ-006 The block SHALL have port mem_ack, input, 1, memory has valid mem_rdata this cycle.
REQ-007 The block SHALL have port mem_rdata, input, 8, fetched byte.
REQ-008 The block SHALL have port opcode, output, 24, assembled instruction {byte0, byte1, byte2}.
REQ-009 The block SHALL have port op_len, output, 2, byte count of the held instruction (1-3).
REQ-010 The block SHALL have port op_illegal, output, 1, held instruction has length code 2'b11.
REQ-011 The block SHALL have port op_valid, output, 1, opcode/op_len/op_illegal stable and offered to execute.
REQ-012 The block SHALL have port op_ready, input, 1, execute accepts the offered instruction.
REQ-013 The block SHALL have port jump_en, input, 1, redirect fetch at acceptance.
REQ-014 The block SHALL have port jump_addr, input, 8, redirect target.
REQ-015 The block SHALL have port halt, input, 1, stop fetching after the accepted instruction.
REQ-016 The block SHALL have port halted, output, 1, sequencer is in HALTED.

Function
REQ-017 The FSM SHALL have states FETCH0, FETCHN, ISSUE, HALTED.
REQ-018 In FETCH0 and FETCHN, mem_req SHALL be 1; in ISSUE and HALTED, mem_req SHALL be 0.
REQ-019 A byte SHALL be accepted only on a cycle with mem_req=1 and mem_ack=1; on that edge it is stored and pc increments by 1, wrapping 8'hFF->8'h00.
REQ-020 In FETCH0, an accepted byte SHALL become byte0; byte1 and byte2 are cleared to 0 on the same edge.
REQ-021 The length code of byte0[7:6] SHALL decode as 00->1, 01->2, 10->3, 11->1 with op_illegal=1.
REQ-022 On acceptance in FETCH0, the FSM SHALL go to ISSUE if the length is 1, else to FETCHN.
REQ-023 In FETCHN, accepted bytes SHALL fill byte1 then byte2; after the last byte of the length, the FSM SHALL go to ISSUE.
REQ-024 mem_ack while mem_req=0 SHALL be ignored.
REQ-025 Wait states SHALL be unbounded; mem_addr SHALL hold while mem_ack=0.
REQ-026 op_valid SHALL be 1 exactly while in ISSUE; opcode, op_len and op_illegal SHALL be stable throughout ISSUE.
REQ-027 Minimum latency from the last-byte acceptance edge to op_valid=1 SHALL be 1 cycle.
REQ-028 Acceptance SHALL occur on a cycle with op_valid=1 and op_ready=1; op_ready outside ISSUE SHALL be ignored.
REQ-029 At acceptance with jump_en=1, pc SHALL load jump_addr; otherwise pc is unchanged (already points past the instruction).
REQ-030 At acceptance with halt=1, the FSM SHALL go to HALTED; otherwise it SHALL go to FETCH0.
REQ-031 If halt=1 and jump_en=1 at acceptance, pc SHALL load jump_addr and the FSM SHALL still go to HALTED.
REQ-032 jump_en and halt SHALL have no effect outside an acceptance cycle.
REQ-033 HALTED SHALL be exited only by reset; halted=1 in HALTED.
REQ-034 A minimum 1-byte instruction with an immediate ack and immediate op_ready SHALL take 2 cycles per instruction.

Reset
REQ-035 While rst_n=0, the block SHALL force: state FETCH0, pc=RESET_PC, bytes=0, op_valid=0, halted=0, op_len=1, op_illegal=0, opcode=0.
REQ-036 Reset assertion mid-fetch or mid-issue SHALL discard the partial instruction immediately, without waiting for a clock edge.
REQ-037 After rst_n deasserts, mem_req SHALL be 1 at mem_addr=RESET_PC on the first cycle.

Verification
REQ-038 Single byte: mem 0x00=0x05 with ack in the request cycle -> op_valid next cycle, opcode=0x050000, op_len=1; pc=0x01.
REQ-039 Three bytes with waits: bytes 0x8A,0x11,0x22 each acked after 2 wait cycles -> mem_addr holds during waits; opcode=0x8A1122, op_len=3.
REQ-040 Backpressure: op_ready=0 for 4 cycles -> op_valid and opcode hold; mem_req stays 0 until acceptance.
REQ-041 Jump and halt: accept with jump_en=1, jump_addr=0x40 -> next mem_addr=0x40; accept with halt=1 -> halted=1, mem_req stays 0 for 10 cycles.
REQ-042 Illegal and wrap: RESET_PC=0xFF, byte 0xC3 -> op_illegal=1, op_len=1; next mem_addr=0x00.
REQ-043 Async reset: assert rst_n=0 between edges while in FETCHN -> outputs reach reset values before the next edge; refetch starts at RESET_PC.
